// File: rtl/iob_uart_driver_if.sv
// iob_uart_driver_if: IOb request/response bus between the UART driver
// (manager) and the UART CSR block (subordinate).
// Handshake rules: a request transfers on a clock edge where iob_valid_o and
// iob_ready_i are both 1, and the manager holds addr/wdata/wstrb stable while
// iob_valid_o=1. Read data transfers on an edge where iob_rvalid_i and
// iob_rready_o are both 1.
interface iob_uart_driver_if #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 32
);
  logic                iob_valid_o;
  logic [ADDR_W-1:0]   iob_addr_o;
  logic [DATA_W-1:0]   iob_wdata_o;
  logic [DATA_W/8-1:0] iob_wstrb_o;
  logic                iob_ready_i;
  logic                iob_rvalid_i;
  logic [DATA_W-1:0]   iob_rdata_i;
  logic                iob_rready_o;

  modport master (
    output iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o, iob_rready_o,
    input  iob_ready_i, iob_rvalid_i, iob_rdata_i
  );

  modport slave (
    input  iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o, iob_rready_o,
    output iob_ready_i, iob_rvalid_i, iob_rdata_i
  );
endinterface

// File: rtl/iob_uart_driver.sv
// iob_uart_driver: IOb manager that initialises a UART CSR block, then polls
// its status word and moves bytes between the tx/rx byte streams and the
// UART data register, one outstanding bus request at a time.
// Optional receive path: define IOB_UART_DRIVER_RX_EN. Without it the RXEN and
// RX_RD states do not exist, rxready is ignored and the rx outputs are 0.
// Byte stream handshakes: tx transfers on an edge with tx_valid_i=1 and
// tx_ready_o=1; rx transfers on an edge with rx_valid_o=1 and rx_ready_i=1.
// dbg_state_o exposes the current FSM state encoding.
module iob_uart_driver #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 32
) (
  input  logic             clk_i,
  input  logic             cke_i,
  input  logic             arst_n_i,
  input  logic             start_i,
  input  logic [15:0]      div_i,
  output logic             init_done_o,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  iob_uart_driver_if.master iob,
  output logic [3:0]       dbg_state_o
);
  localparam int STRB_W = DATA_W / 8;

`ifdef IOB_UART_DRIVER_RX_EN
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_SRST_SET = 4'd1, S_SRST_CLR = 4'd2, S_DIV = 4'd3,
    S_TXEN = 4'd4, S_RXEN = 4'd5, S_POLL = 4'd6, S_RX_RD = 4'd7, S_TX_WR = 4'd8
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_SRST_SET = 4'd1, S_SRST_CLR = 4'd2, S_DIV = 4'd3,
    S_TXEN = 4'd4, S_POLL = 4'd6, S_TX_WR = 4'd8
  } state_t;
`endif

  state_t              r_state, w_state_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_rready, w_rready_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt, w_req_addr;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt, w_req_wdata;
  logic [STRB_W-1:0]   r_wstrb, w_wstrb_nxt, w_req_wstrb;
  logic [15:0]         r_div, w_div_nxt;
  logic                r_init_done, w_init_done_nxt;
  logic                w_tx_ready;
  logic                w_unused;
`ifdef IOB_UART_DRIVER_RX_EN
  logic                r_rx_valid, w_rx_valid_nxt;
  logic [7:0]          r_rx_data, w_rx_data_nxt;
`endif

  // State register and all registered outputs; reset forces IDLE at once.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_rready    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_div       <= '0;
      r_init_done <= 1'b0;
`ifdef IOB_UART_DRIVER_RX_EN
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_valid     <= w_valid_nxt;
      r_rready    <= w_rready_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_div       <= w_div_nxt;
      r_init_done <= w_init_done_nxt;
`ifdef IOB_UART_DRIVER_RX_EN
      r_rx_valid  <= w_rx_valid_nxt;
      r_rx_data   <= w_rx_data_nxt;
`endif
    end
  end

  // Next state, bus request sequencing and byte stream handshakes.
  always_comb begin
    w_state_nxt     = r_state;
    w_valid_nxt     = r_valid;
    w_rready_nxt    = r_rready;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_div_nxt       = r_div;
    w_init_done_nxt = r_init_done;
    w_tx_ready      = 1'b0;
`ifdef IOB_UART_DRIVER_RX_EN
    w_rx_valid_nxt  = r_rx_valid;
    w_rx_data_nxt   = r_rx_data;
`endif
    w_req_addr      = '0;
    w_req_wstrb     = '0;
    w_req_wdata     = '0;

    // Request each state issues; a zero strobe is a read.
    case (r_state)
      S_SRST_SET: begin w_req_wstrb = STRB_W'(4'b0001); w_req_wdata = DATA_W'(32'h1); end
      S_SRST_CLR: begin w_req_wstrb = STRB_W'(4'b0001); end
      S_DIV:      begin w_req_wstrb = STRB_W'(4'b1100); w_req_wdata = DATA_W'({r_div, 16'h0}); end
      S_TXEN:     begin w_req_addr = ADDR_W'(1); w_req_wstrb = STRB_W'(4'b0010); w_req_wdata = DATA_W'(32'h100); end
`ifdef IOB_UART_DRIVER_RX_EN
      S_RXEN:     begin w_req_addr = ADDR_W'(1); w_req_wstrb = STRB_W'(4'b0100); w_req_wdata = DATA_W'(32'h10000); end
      S_RX_RD:    begin w_req_addr = ADDR_W'(1); end
`endif
      S_TX_WR:    begin w_req_addr = ADDR_W'(1); w_req_wstrb = STRB_W'(4'b0001); w_req_wdata = DATA_W'(tx_data_i); end
      default:    ;
    endcase

    if (cke_i) begin
      if (r_state == S_IDLE) begin
        if (start_i) begin
          w_state_nxt = S_SRST_SET;
          w_div_nxt   = div_i;
        end
      end else if (!r_valid && !r_rready) begin
        // Nothing outstanding: launch this state's request.
        w_valid_nxt = 1'b1;
        w_addr_nxt  = w_req_addr;
        w_wdata_nxt = w_req_wdata;
        w_wstrb_nxt = w_req_wstrb;
      end else if (r_valid && iob.iob_ready_i) begin
        w_valid_nxt = 1'b0;
        if (r_wstrb == '0) begin
          w_rready_nxt = 1'b1;
        end else begin
          case (r_state)
            S_SRST_SET: w_state_nxt = S_SRST_CLR;
            S_SRST_CLR: w_state_nxt = S_DIV;
            S_DIV:      w_state_nxt = S_TXEN;
`ifdef IOB_UART_DRIVER_RX_EN
            S_TXEN:     w_state_nxt = S_RXEN;
            S_RXEN:     begin w_state_nxt = S_POLL; w_init_done_nxt = 1'b1; end
`else
            S_TXEN:     begin w_state_nxt = S_POLL; w_init_done_nxt = 1'b1; end
`endif
            S_TX_WR:    begin w_state_nxt = S_POLL; w_tx_ready = 1'b1; end
            default:    ;
          endcase
        end
      end else if (r_rready && iob.iob_rvalid_i) begin
        w_rready_nxt = 1'b0;
`ifdef IOB_UART_DRIVER_RX_EN
        if (r_state == S_RX_RD) begin
          w_rx_data_nxt  = iob.iob_rdata_i[7:0];
          w_rx_valid_nxt = 1'b1;
          w_state_nxt    = S_POLL;
        end else if (iob.iob_rdata_i[8] && !r_rx_valid) begin
          w_state_nxt = S_RX_RD;
        end else
`endif
        if (iob.iob_rdata_i[0] && tx_valid_i) begin
          w_state_nxt = S_TX_WR;
        end else begin
          w_state_nxt = S_POLL;
        end
      end
`ifdef IOB_UART_DRIVER_RX_EN
      // Consumer took the held byte; the holding register frees next cycle.
      if (r_rx_valid && rx_ready_i) begin
        w_rx_valid_nxt = 1'b0;
      end
`endif
    end
  end

  assign iob.iob_valid_o  = r_valid;
  assign iob.iob_addr_o   = r_addr;
  assign iob.iob_wdata_o  = r_wdata;
  assign iob.iob_wstrb_o  = r_wstrb;
  assign iob.iob_rready_o = r_rready;
  assign init_done_o      = r_init_done;
  assign tx_ready_o       = w_tx_ready;
  assign dbg_state_o      = r_state;
`ifdef IOB_UART_DRIVER_RX_EN
  assign rx_valid_o = r_rx_valid;
  assign rx_data_o  = r_rx_data;
  assign w_unused   = ^iob.iob_rdata_i[DATA_W-1:9];
`else
  assign rx_valid_o = 1'b0;
  assign rx_data_o  = 8'h00;
  assign w_unused   = ^{iob.iob_rdata_i[DATA_W-1:1], rx_ready_i};
`endif
endmodule

// File: doc/iob_uart_driver.md
IOB_UART_DRIVER -- requirements
Module: iob_uart_driver

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 1, meaning the IOb word address width (0 = bytes 0-3, 1 = bytes 4-7).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the IOb data width; only 32 is supported.
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-004 Port: clk_i, input, 1, system clock.
REQ-005 Port: cke_i, input, 1, clock enable; when low, all state holds.
REQ-006 Port: arst_n_i, input, 1, asynchronous active-low reset.
REQ-007 Port: start_i, input, 1, one-cycle pulse that begins the UART init sequence.
REQ-008 Port: div_i, input, 16, baud divisor; sampled on start_i.
REQ-009 Port: init_done_o, output, 1, high once init completes.
REQ-010 Port: tx_data_i, input, 8, byte to transmit.
REQ-011 Port: tx_valid_i, input, 1, tx byte valid.
REQ-012 Port: tx_ready_o, output, 1, tx byte accepted.
REQ-013 Port: rx_data_o, output, 8, received byte.
REQ-014 Port: rx_valid_o, output, 1, rx holding register full.
REQ-015 Port: rx_ready_i, input, 1, consumer takes the rx byte.
REQ-016 Port: iob_valid_o, output, 1, request valid.
REQ-017 Port: iob_addr_o, output, ADDR_W, word address.
REQ-018 Port: iob_wdata_o, output, 32, write data.
REQ-019 Port: iob_wstrb_o, output, 4, byte strobes; 0 means read.
REQ-020 Port: iob_ready_i, input, 1, request accepted.
REQ-021 Port: iob_rvalid_i, input, 1, read data valid.
REQ-022 Port: iob_rdata_i, input, 32, read data.
REQ-023 Port: iob_rready_o, output, 1, read data accepted.

Function
REQ-024 The block SHALL act as IOb manager for the UART CSR subordinate, with one outstanding request at a time.
REQ-025 The block SHALL hold valid/addr/wdata/wstrb stable from assertion until the cycle iob_ready_i=1 is sampled, then drop valid in the next cycle.
REQ-026 For reads, the block SHALL hold iob_rready_o=1 from request acceptance and complete on the first cycle with iob_rvalid_i=1, capturing iob_rdata_i in that cycle.
REQ-027 FSM states SHALL be IDLE, SRST_SET, SRST_CLR, DIV, TXEN, RXEN, POLL, RX_RD, TX_WR.
REQ-028 On start_i, IDLE SHALL go to SRST_SET; start_i SHALL be ignored in all other states.
REQ-029 Init writes SHALL be issued in order:
- SRST_SET: addr 0, wstrb 0001, wdata[0]=1
- SRST_CLR: addr 0, wstrb 0001, wdata[0]=0
- DIV: addr 0, wstrb 1100, wdata[31:16]=div
- TXEN: addr 1, wstrb 0010, wdata[8]=1
- RXEN: addr 1, wstrb 0100, wdata[16]=1
REQ-030 Each init state SHALL advance on write acceptance; unused wdata bits SHALL be 0.
REQ-031 init_done_o SHALL rise in the cycle after RXEN acceptance and remain high until reset.
REQ-032 POLL SHALL read addr 0; bit0 = txready and bit8 = rxready.
REQ-033 After POLL, if rxready=1 and rx_valid_o=0, the next state SHALL be RX_RD; else if txready=1 and tx_valid_i=1, TX_WR; else POLL.
REQ-034 RX SHALL take priority over TX when both are eligible.
REQ-035 RX_RD SHALL read addr 1, load rdata[7:0] into rx_data_o, set rx_valid_o, and return to POLL.
REQ-036 TX_WR SHALL write addr 1, wstrb 0001, wdata[7:0]=tx_data_i, and pulse tx_ready_o for exactly the acceptance cycle.
REQ-037 tx_data_i SHALL be sampled at request assertion; the source SHALL hold it stable while tx_valid_i=1.
REQ-038 rx_valid_o SHALL clear in the cycle after rx_valid_o&rx_ready_i.
REQ-039 A new rx byte SHALL never overwrite an unconsumed byte.
REQ-040 tx_ready_o SHALL remain 0 before init_done_o.

Reset
REQ-041 On arst_n_i low, the state SHALL go to IDLE immediately, including mid-transaction, and all outputs SHALL be 0: iob_valid_o, iob_rready_o, tx_ready_o, rx_valid_o, rx_data_o, init_done_o.
REQ-042 After reset release, no bus activity SHALL occur until start_i.

Configuration
REQ-043 IOB_UART_DRIVER_RX_EN defined: full behaviour as above.
REQ-044 IOB_UART_DRIVER_RX_EN undefined: the RXEN and RX_RD states SHALL be absent, init_done_o SHALL rise after TXEN acceptance, POLL SHALL ignore rxready, rx_valid_o and rx_data_o SHALL be tied to 0, and rx_ready_i SHALL be ignored.

Verification
REQ-045 Reset, start_i with div_i=0x0036, zero-wait subordinate -> five writes: (0,0001,0x1), (0,0001,0x0), (0,1100,0x00360000), (1,0010,0x100), (1,0100,0x10000); then init_done_o=1.
REQ-046 Subordinate inserts 3 wait cycles on ready -> request fields stable for all 4 cycles; one request only.
REQ-047 POLL returns 0x0101, tx_valid_i=1 with 0x41 -> RX_RD read of addr 1 first, rx_data_o=rdata[7:0]; next POLL returns 0x0001 -> TX write wdata=0x41, single tx_ready_o pulse.
REQ-048 rx_ready_i held 0 while POLL returns rxready=1 -> no further addr 1 reads; rx_data_o unchanged.
REQ-049 arst_n_i asserted while iob_valid_o=1 in DIV -> all outputs 0 that cycle; after release, no request until start_i.
REQ-050 With RX_EN undefined -> init ends after TXEN write; no addr 1 reads ever issued.
